// File: rtl/ialu_decode.sv
// Registered RV64I/RV32I integer decode stage feeding the ALU. A main entry
// drives the outputs and a skid entry absorbs one extra beat so in_ready is a flop.
module ialu_decode #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [DW-1:0] in_rs1,
  input  logic [DW-1:0] in_rs2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] op_rs1,
  output logic [DW-1:0] op_rs2,
  output logic          de_add,
  output logic          de_sub,
  output logic          de_sll,
  output logic          de_srl,
  output logic          de_sra,
  output logic          de_and,
  output logic          de_or,
  output logic          de_xor,
  output logic          de_sltu,
  output logic          de_slt,
  output logic          de_sext,
  output logic [4:0]    de_rd,
  output logic          de_illegal
);

  // Handshake: a beat moves in on in_valid & in_ready and out on
  // out_valid & out_ready; flush drops everything and wins over both.

  localparam logic [10:0] C_ADD  = 11'b100_0000_0000;
  localparam logic [10:0] C_SUB  = 11'b010_0000_0000;
  localparam logic [10:0] C_SLL  = 11'b001_0000_0000;
  localparam logic [10:0] C_SRL  = 11'b000_1000_0000;
  localparam logic [10:0] C_SRA  = 11'b000_0100_0000;
  localparam logic [10:0] C_AND  = 11'b000_0010_0000;
  localparam logic [10:0] C_OR   = 11'b000_0001_0000;
  localparam logic [10:0] C_XOR  = 11'b000_0000_1000;
  localparam logic [10:0] C_SLTU = 11'b000_0000_0100;
  localparam logic [10:0] C_SLT  = 11'b000_0000_0010;
  localparam logic [10:0] C_SEXT = 11'b000_0000_0001;
  localparam logic        IS64   = (DW == 64);

  typedef struct packed {
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [10:0]   ctl;
    logic [4:0]    rd;
    logic          illegal;
  } entry_t;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [5:0]  hi6;
  logic [63:0] sx12_w;
  logic [63:0] shamt_w;
  logic [63:0] lui_w;
  logic [10:0] f3_ctl;
  logic        legal;
  entry_t      dec;

  assign opc     = in_instr[6:0];
  assign f3      = in_instr[14:12];
  assign f7      = in_instr[31:25];
  assign hi6     = in_instr[31:26];
  assign sx12_w  = {{52{in_instr[31]}}, in_instr[31:20]};
  assign shamt_w = {58'b0, in_instr[25:20]};
  assign lui_w   = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};

  // Compares run through the subtractor, so slt/sltu also raise de_sub.
  always_comb begin
    f3_ctl = '0;
    case (f3)
      3'b000:  f3_ctl = C_ADD;
      3'b001:  f3_ctl = C_SLL;
      3'b010:  f3_ctl = C_SUB | C_SLT;
      3'b011:  f3_ctl = C_SUB | C_SLTU;
      3'b100:  f3_ctl = C_XOR;
      3'b101:  f3_ctl = C_SRL;
      3'b110:  f3_ctl = C_OR;
      default: f3_ctl = C_AND;
    endcase
  end

  always_comb begin
    legal       = 1'b0;
    dec.ctl     = '0;
    dec.rs1     = in_rs1;
    dec.rs2     = in_rs2;
    dec.rd      = in_instr[11:7];
    case (opc)
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          legal   = 1'b1;
          dec.ctl = f3_ctl;
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          legal   = 1'b1;
          dec.ctl = C_ADD | C_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          legal   = 1'b1;
          dec.ctl = C_SRA;
        end
      end
      7'b0010011: begin
        if (f3 == 3'b001) begin
          legal   = (hi6 == 6'b000000) && (IS64 || !in_instr[25]);
          dec.ctl = C_SLL;
          dec.rs2 = shamt_w[DW-1:0];
        end else if (f3 == 3'b101) begin
          legal   = (hi6 == 6'b000000 || hi6 == 6'b010000) && (IS64 || !in_instr[25]);
          dec.ctl = in_instr[30] ? C_SRA : C_SRL;
          dec.rs2 = shamt_w[DW-1:0];
        end else begin
          legal   = 1'b1;
          dec.ctl = f3_ctl;
          dec.rs2 = sx12_w[DW-1:0];
        end
      end
      7'b0111011: begin
        if (IS64) begin
          if (f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) begin
            legal   = 1'b1;
            dec.ctl = f3_ctl | C_SEXT;
          end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
            legal   = 1'b1;
            dec.ctl = C_ADD | C_SUB | C_SEXT;
          end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
            legal   = 1'b1;
            dec.ctl = C_SRA | C_SEXT;
          end
        end
      end
      7'b0011011: begin
        if (IS64) begin
          if (f3 == 3'b000) begin
            legal   = 1'b1;
            dec.ctl = C_ADD | C_SEXT;
            dec.rs2 = sx12_w[DW-1:0];
          end else if (f3 == 3'b001) begin
            legal   = (f7 == 7'b0000000);
            dec.ctl = C_SLL | C_SEXT;
            dec.rs2 = shamt_w[DW-1:0];
          end else if (f3 == 3'b101) begin
            legal   = (f7 == 7'b0000000 || f7 == 7'b0100000);
            dec.ctl = (in_instr[30] ? C_SRA : C_SRL) | C_SEXT;
            dec.rs2 = shamt_w[DW-1:0];
          end
        end
      end
      7'b0110111: begin
        legal   = 1'b1;
        dec.ctl = C_ADD;
        dec.rs1 = '0;
        dec.rs2 = lui_w[DW-1:0];
      end
      default: legal = 1'b0;
    endcase
    // Illegal entries still travel down the pipe, with raw operands and no controls.
    if (!legal) begin
      dec.ctl = '0;
      dec.rs1 = in_rs1;
      dec.rs2 = in_rs2;
    end
    dec.illegal = !legal;
  end

  entry_t main_q, skid_q;
  logic   main_valid, skid_valid;
  logic   main_valid_n, skid_valid_n;
  logic   main_load_skid, main_load_in, skid_load;
  logic   accept, consume;

  assign accept  = in_valid & in_ready;
  assign consume = main_valid & out_ready;

  always_comb begin
    main_valid_n   = main_valid;
    skid_valid_n   = skid_valid;
    main_load_skid = 1'b0;
    main_load_in   = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (!main_valid || consume) begin
      if (skid_valid) begin
        main_load_skid = 1'b1;
        main_valid_n   = 1'b1;
        skid_valid_n   = 1'b0;
      end else if (accept) begin
        main_load_in = 1'b1;
        main_valid_n = 1'b1;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (accept) begin
      skid_load    = 1'b1;
      skid_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      in_ready   <= ~skid_valid_n;
      if (main_load_skid)    main_q <= skid_q;
      else if (main_load_in) main_q <= dec;
      if (skid_load)         skid_q <= dec;
    end
  end

  assign out_valid  = main_valid;
  assign op_rs1     = main_q.rs1;
  assign op_rs2     = main_q.rs2;
  assign de_rd      = main_q.rd;
  assign de_illegal = main_q.illegal;
  assign {de_add, de_sub, de_sll, de_srl, de_sra, de_and,
          de_or, de_xor, de_sltu, de_slt, de_sext} = main_q.ctl;

endmodule

// File: tb/tb_ialu_decode.sv
// Bench for ialu_decode: 64-bit and 32-bit instances driven in lockstep,
// checked against a mnemonic-level decode model and an entry-count queue model.
module tb_ialu_decode;

  localparam int W = 145;
  localparam logic [10:0] C_ADD  = 11'b100_0000_0000;
  localparam logic [10:0] C_SUB  = 11'b010_0000_0000;
  localparam logic [10:0] C_SLL  = 11'b001_0000_0000;
  localparam logic [10:0] C_SRL  = 11'b000_1000_0000;
  localparam logic [10:0] C_SRA  = 11'b000_0100_0000;
  localparam logic [10:0] C_AND  = 11'b000_0010_0000;
  localparam logic [10:0] C_OR   = 11'b000_0001_0000;
  localparam logic [10:0] C_XOR  = 11'b000_0000_1000;
  localparam logic [10:0] C_SLTU = 11'b000_0000_0100;
  localparam logic [10:0] C_SLT  = 11'b000_0000_0010;
  localparam logic [10:0] C_SEXT = 11'b000_0000_0001;

  logic        clk = 1'b0;
  logic        nreset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_rs1, in_rs2;

  logic        in_ready, out_valid, de_illegal;
  logic [63:0] op_rs1, op_rs2;
  logic        de_add, de_sub, de_sll, de_srl, de_sra, de_and, de_or, de_xor, de_sltu, de_slt, de_sext;
  logic [4:0]  de_rd;

  logic        s_in_ready, s_out_valid, s_de_illegal;
  logic [31:0] s_op_rs1, s_op_rs2;
  logic        s_add, s_sub, s_sll, s_srl, s_sra, s_and, s_or, s_xor, s_sltu, s_slt, s_sext;
  logic [4:0]  s_de_rd;

  ialu_decode #(.DW(64)) u_dut (
    .clk(clk), .nreset(nreset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .out_valid(out_valid),
    .out_ready(out_ready), .op_rs1(op_rs1), .op_rs2(op_rs2), .de_add(de_add), .de_sub(de_sub),
    .de_sll(de_sll), .de_srl(de_srl), .de_sra(de_sra), .de_and(de_and), .de_or(de_or),
    .de_xor(de_xor), .de_sltu(de_sltu), .de_slt(de_slt), .de_sext(de_sext), .de_rd(de_rd),
    .de_illegal(de_illegal)
  );

  ialu_decode #(.DW(32)) u_dut32 (
    .clk(clk), .nreset(nreset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_instr(in_instr), .in_rs1(in_rs1[31:0]), .in_rs2(in_rs2[31:0]), .out_valid(s_out_valid),
    .out_ready(out_ready), .op_rs1(s_op_rs1), .op_rs2(s_op_rs2), .de_add(s_add), .de_sub(s_sub),
    .de_sll(s_sll), .de_srl(s_srl), .de_sra(s_sra), .de_and(s_and), .de_or(s_or),
    .de_xor(s_xor), .de_sltu(s_sltu), .de_slt(s_slt), .de_sext(s_sext), .de_rd(s_de_rd),
    .de_illegal(s_de_illegal)
  );

  // Clock and reset
  always #5 clk = ~clk;

  logic [10:0]  ctl64, ctl32;
  logic [W-1:0] got64, got32;
  assign ctl64 = {de_add, de_sub, de_sll, de_srl, de_sra, de_and, de_or, de_xor, de_sltu, de_slt, de_sext};
  assign ctl32 = {s_add, s_sub, s_sll, s_srl, s_sra, s_and, s_or, s_xor, s_sltu, s_slt, s_sext};
  assign got64 = {op_rs1, op_rs2, ctl64, de_rd, de_illegal};
  assign got32 = {32'b0, s_op_rs1, 32'b0, s_op_rs2, ctl32, s_de_rd, s_de_illegal};

  // Scoreboard
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp32_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic string base_name(input logic [2:0] f3);
    case (f3)
      3'd0: return "add";
      3'd1: return "sll";
      3'd2: return "slt";
      3'd3: return "sltu";
      3'd4: return "xor";
      3'd5: return "srl";
      3'd6: return "or";
      default: return "and";
    endcase
  endfunction

  // Reference decode: name the instruction first, then derive controls from the name.
  function automatic logic [W-1:0] model(input logic [31:0] i, input logic [63:0] a,
                                         input logic [63:0] b, input int dw);
    logic [2:0]  f3 = i[14:12];
    logic [6:0]  f7 = i[31:25];
    logic [5:0]  hi6 = i[31:26];
    logic [63:0] imm = {{52{i[31]}}, i[31:20]};
    logic [63:0] sh = {58'b0, i[25:20]};
    logic [63:0] x = a;
    logic [63:0] y = b;
    logic        w = 1'b0;
    logic [10:0] c = '0;
    string       mn = "ill";
    case (i[6:0])
      7'h33: begin
        if (f7 == 0) mn = base_name(f3);
        else if (f7 == 7'h20 && f3 == 0) mn = "sub";
        else if (f7 == 7'h20 && f3 == 5) mn = "sra";
      end
      7'h13: begin
        if (f3 == 1) begin
          if (hi6 == 0) mn = "sll";
          y = sh;
        end else if (f3 == 5) begin
          if (hi6 == 0) mn = "srl";
          else if (hi6 == 6'h10) mn = "sra";
          y = sh;
        end else begin
          mn = base_name(f3);
          y = imm;
        end
        if (dw == 32 && (f3 == 1 || f3 == 5) && i[25]) mn = "ill";
      end
      7'h3B: if (dw == 64) begin
        w = 1'b1;
        if (f7 == 0 && (f3 == 0 || f3 == 1 || f3 == 5)) mn = base_name(f3);
        else if (f7 == 7'h20 && f3 == 0) mn = "sub";
        else if (f7 == 7'h20 && f3 == 5) mn = "sra";
      end
      7'h1B: if (dw == 64) begin
        w = 1'b1;
        if (f3 == 0) begin mn = "add"; y = imm; end
        else if (f3 == 1 && f7 == 0) begin mn = "sll"; y = sh; end
        else if (f3 == 5 && f7 == 0) begin mn = "srl"; y = sh; end
        else if (f3 == 5 && f7 == 7'h20) begin mn = "sra"; y = sh; end
      end
      7'h37: begin
        mn = "add";
        x = '0;
        y = {{32{i[31]}}, i[31:12], 12'b0};
      end
      default: mn = "ill";
    endcase
    case (mn)
      "add":  c = C_ADD;
      "sub":  c = C_ADD | C_SUB;
      "sll":  c = C_SLL;
      "srl":  c = C_SRL;
      "sra":  c = C_SRA;
      "and":  c = C_AND;
      "or":   c = C_OR;
      "xor":  c = C_XOR;
      "slt":  c = C_SUB | C_SLT;
      "sltu": c = C_SUB | C_SLTU;
      default: c = '0;
    endcase
    if (mn == "ill") begin
      x = a;
      y = b;
    end else if (w) begin
      c = c | C_SEXT;
    end
    if (dw == 32) begin
      x[63:32] = '0;
      y[63:32] = '0;
    end
    return {x, y, c, i[11:7], (mn == "ill")};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i = $urandom;
    int k = $urandom_range(0, 9);
    int m = $urandom_range(0, 3);
    case (k)
      0, 1:    i[6:0] = 7'h33;
      2, 3:    i[6:0] = 7'h13;
      4:       i[6:0] = 7'h3B;
      5, 6:    i[6:0] = 7'h1B;
      7:       i[6:0] = 7'h37;
      default: ;
    endcase
    if (m == 0) i[31:25] = 7'h00;
    else if (m == 1) i[31:25] = 7'h20;
    else if (m == 2) i[31:26] = 6'h00;
    return i;
  endfunction

  // Driver: one cycle of stimulus, then check the present outputs and update the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] a,
                      input logic [63:0] b, input logic ordy, input logic fl);
    logic ready_m;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_rs1 = a; in_rs2 = b; out_ready = ordy; flush = fl;
    #1;
    ready_m = (exp_q.size() < 2);
    check("in_ready", in_ready, ready_m);
    check("out_valid", out_valid, exp_q.size() > 0);
    check("in_ready32", s_in_ready, ready_m);
    check("out_valid32", s_out_valid, exp32_q.size() > 0);
    if (exp_q.size() > 0) check("entry64", got64, exp_q[0]);
    if (exp32_q.size() > 0) check("entry32", got32, exp32_q[0]);
    if (fl) begin
      exp_q.delete();
      exp32_q.delete();
    end else begin
      if (exp_q.size() > 0 && ordy) begin
        void'(exp_q.pop_front());
        void'(exp32_q.pop_front());
      end
      if (v && ready_m) begin
        exp_q.push_back(model(ins, a, b, 64));
        exp32_q.push_back(model(ins, a, b, 32));
      end
    end
  endtask

  typedef struct {
    logic [31:0] i;
    logic [63:0] a, b;
    logic [10:0] c;
    logic [63:0] x, y;
    logic        ill, ill32;
  } dir_t;

  dir_t dirs [9] = '{
    '{32'h002081B3, 64'd5, 64'd7, C_ADD, 64'd5, 64'd7, 1'b0, 1'b0},
    '{32'hFFF00093, 64'd9, 64'd3, C_ADD, 64'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0},
    '{32'h41F0D09B, 64'h123, 64'h55, C_SRA | C_SEXT, 64'h123, 64'd31, 1'b0, 1'b1},
    '{32'h0020A1B3, 64'd1, 64'd2, C_SUB | C_SLT, 64'd1, 64'd2, 1'b0, 1'b0},
    '{32'h402081B3, 64'd8, 64'd3, C_ADD | C_SUB, 64'd8, 64'd3, 1'b0, 1'b0},
    '{32'h0000007F, 64'hAA, 64'hBB, 11'd0, 64'hAA, 64'hBB, 1'b1, 1'b1},
    '{32'h0410D093, 64'h11, 64'h22, 11'd0, 64'h11, 64'h22, 1'b1, 1'b1},
    '{32'h002081BB, 64'd4, 64'd6, C_ADD | C_SEXT, 64'd4, 64'd6, 1'b0, 1'b1},
    '{32'h80000037, 64'h77, 64'h88, C_ADD, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0}
  };

  initial begin
    nreset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_rs1 = '0; in_rs2 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out64", got64, '0);
    check("rst_out32", got32, '0);
    nreset = 1'b1;

    // Directed decode cases with hand-derived expectations
    foreach (dirs[k]) begin
      step(1'b1, dirs[k].i, dirs[k].a, dirs[k].b, 1'b1, 1'b0);
      step(1'b0, '0, '0, '0, 1'b1, 1'b0);
      check($sformatf("dir%0d_valid", k), out_valid, 1'b1);
      check($sformatf("dir%0d_ctl", k), ctl64, dirs[k].c);
      check($sformatf("dir%0d_rs1", k), op_rs1, dirs[k].x);
      check($sformatf("dir%0d_rs2", k), op_rs2, dirs[k].y);
      check($sformatf("dir%0d_rd", k), de_rd, dirs[k].i[11:7]);
      check($sformatf("dir%0d_ill", k), de_illegal, dirs[k].ill);
      check($sformatf("dir%0d_ill32", k), s_de_illegal, dirs[k].ill32);
    end
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);

    // Back-pressure: three offers while the consumer stalls
    step(1'b1, 32'h002081B3, 64'd1, 64'd1, 1'b0, 1'b0);
    step(1'b1, 32'h402081B3, 64'd2, 64'd2, 1'b0, 1'b0);
    step(1'b1, 32'h0020A1B3, 64'd3, 64'd3, 1'b0, 1'b0);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_head", op_rs1, 64'd1);
    step(1'b1, 32'h0020A1B3, 64'd3, 64'd3, 1'b0, 1'b0);
    repeat (4) step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    check("stall_drained", out_valid, 1'b0);

    // Flush with both entries occupied
    step(1'b1, 32'h002081B3, 64'd4, 64'd4, 1'b0, 1'b0);
    step(1'b1, 32'h002081B3, 64'd5, 64'd5, 1'b0, 1'b0);
    step(1'b1, 32'h002081B3, 64'd6, 64'd6, 1'b0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);

    // Asynchronous reset pulse between clock edges
    step(1'b1, 32'h002081B3, 64'd7, 64'd7, 1'b0, 1'b0);
    step(1'b1, 32'h002081B3, 64'd8, 64'd8, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 nreset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out64", got64, '0);
    exp_q.delete();
    exp32_q.delete();
    #1 nreset = 1'b1;

    // Randomized traffic with random back-pressure and occasional flush
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end
    repeat (3) step(1'b0, '0, '0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ialu_decode.md
# ialu_decode

Registered decode stage that sits directly upstream of the integer ALU. It accepts a 32-bit RV64I/RV32I integer instruction together with its already-read source register values over a valid/ready handshake. It produces the ALU operands, one-hot `de_*` controls, the destination register index and an illegal-instruction flag one cycle later. A two-entry skid buffer breaks the ready path, so `in_ready` is a pure register output.

## Interface
- DW, 64, datapath width; legal values 32 or 64
- clk  input  1  clock, all state updates on rising edge
- nreset  input  1  asynchronous active-low reset
- flush  input  1  synchronous discard of all buffered entries
- in_valid  input  1  instruction and operands valid
- in_ready  output  1  stage can accept; registered
- in_instr  input  32  instruction word
- in_rs1  input  DW  rs1 register value
- in_rs2  input  DW  rs2 register value
- out_valid  output  1  decoded entry valid
- out_ready  input  1  ALU consumes entry
- op_rs1, op_rs2  output  DW  ALU operands
- de_add, de_sub, de_sll, de_srl, de_sra, de_and, de_or, de_xor, de_sltu, de_slt, de_sext  output  1 each  ALU controls
- de_rd  output  5  destination register, `in_instr[11:7]`
- de_illegal  output  1  instruction not decodable

## Operation
- Storage: main entry (drives outputs) plus one skid entry. Each entry holds all decoded fields.
- Transfer occurs on `in_valid & in_ready`. Output transfer occurs on `out_valid & out_ready`.
- Decode is purely from `in_instr`. Definitions: sx12 = sign-extended `instr[31:20]`; shamt = zero-extended `instr[25:20]`.
- Opcode 0110011 (OP), op_rs1=in_rs1, op_rs2=in_rs2:
  - funct7 0000000, funct3 000..111: add, sll, slt, sltu, xor, srl, or, and
  - funct7 0100000: funct3 000 sub, 101 sra
  - any other combination is illegal
- Opcode 0010011 (OP-IMM), op_rs2=sx12, same funct3 map with no sub:
  - 001 requires `instr[31:26]`=000000
  - 101 requires `instr[31:26]`=000000 (srl) or 010000 (sra)
  - shifts use op_rs2=shamt
  - when DW=32, `instr[25]`=1 is illegal
- Opcode 0111011 (OP-32), de_sext=1, register operands:
  - addw, subw, sllw, srlw, sraw only; funct3 000/001/101 with funct7 rules as OP
  - illegal when DW=32
- Opcode 0011011 (OP-IMM-32), de_sext=1:
  - addiw, slliw, srliw, sraiw
  - shifts require `instr[25]`=0
  - illegal when DW=32
- Opcode 0110111 (LUI): de_add, op_rs1=0, op_rs2=sign-extended `{instr[31:12],12'b0}`.
- Control encoding:
  - sub asserts de_add and de_sub.
  - slt/sltu assert de_sub plus de_slt/de_sltu. The ALU result mux selects the adder only via de_add, and compare needs the subtract.
- Illegal instruction: all ALU controls 0, de_illegal=1, operands pass unmodified. The entry still flows through the handshake.
- Any opcode not listed above is illegal.

## Timing
- Latency: accepted at edge N, visible on outputs after edge N (out_valid=1), one cycle.
- Reset values: out_valid=0, in_ready=1, all data/control outputs 0, skid empty.
- Main entry update:
  - If main is empty, or main is consumed this cycle, it loads the skid entry if the skid is valid, else the input if accepted.
  - If main is full and not consumed, an accepted input goes to skid.
- in_ready next = ~skid_valid_next. in_ready falls only when the skid fills and rises the cycle after the skid drains.
- Full throughput: one instruction per cycle with out_ready held 1.
- Simultaneous accept and consume with skid empty: main replaced, no bubble.
- Simultaneous accept and consume with skid full: cannot occur, since in_ready=0.
- Skid and main both full with out_ready=1: main loads skid, skid empties, in_ready=1 next cycle.
- flush=1 at an edge: out_valid=0, skid empty, in_ready=1 next cycle. Input offered that cycle is discarded. Flush has priority over all transfers.
- nreset asserted mid-operation: immediate clear to reset values, independent of clk.
- Outputs are held stable while out_valid=1 and out_ready=0.

## Test plan
- Reset then `add x3,x1,x2` (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, de_add=1, op_rs1=5, op_rs2=7, de_rd=3, other controls 0.
- `addi x1,x0,-1` (0xFFF00093) -> op_rs2=0xFFFF_FFFF_FFFF_FFFF, de_add=1. `sraiw x1,x1,31` (0x41F0D09B) -> de_sra=1, de_sext=1, op_rs2=31.
- `slt` (0x0020A1B3) -> de_slt=1, de_sub=1, de_add=0. `sub` (0x402081B3) -> de_add=1, de_sub=1.
- out_ready=0 for 3 cycles while offering 3 back-to-back instructions -> first held on outputs, second in skid, in_ready=0 from cycle 2, third not accepted. Release out_ready -> order preserved, no drop or duplicate.
- 0x0000007F and `srai` with `instr[31:26]`=000001 -> de_illegal=1, all controls 0. DW=32 build with `addw` -> de_illegal=1.
- flush with both entries full -> out_valid=0, in_ready=1 next cycle. nreset pulse between edges -> outputs zero immediately.
